// File: rtl/botoes_pkg.sv
// Shared types and helpers for the push-button conditioning path.
package botoes_pkg;

  typedef enum logic [1:0] {
    SOLTO            = 2'd0,
    CONFIRMA_APERTO  = 2'd1,
    APERTADO         = 2'd2,
    CONFIRMA_SOLTURA = 2'd3
  } estado_botao_t;

  localparam int N_BOTOES_PADRAO = 8;
  localparam int DEBOUNCE_PADRAO = 50000;

  // Lowest set bit of v as a one-hot word (zero when v is zero); callers use up to 32 bits.
  function automatic logic [31:0] menor_bit(input logic [31:0] v);
    return v & (~v + 32'd1);
  endfunction

endpackage

// File: rtl/debounce_botao.sv
// One button: two-flop synchroniser, polarity normalisation and debounce FSM.
// confirma_o is combinational so the press reaches the pending register on the accepting edge.
module debounce_botao
  import botoes_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
  parameter int ATIVO_BAIXO     = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic bruto_i,
  output logic estavel_o,
  output logic confirma_o
);

  localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);
  localparam logic NIVEL_SOLTO = (ATIVO_BAIXO != 0);

  logic [1:0]    sync_q;
  logic          p;
  estado_botao_t estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= {2{NIVEL_SOLTO}};
      estado_q <= SOLTO;
      cnt_q    <= '0;
    end else begin
      sync_q   <= {sync_q[0], bruto_i};
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
    end
  end

  assign p = sync_q[1] ^ NIVEL_SOLTO;

  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    confirma_o = 1'b0;
    case (estado_q)
      SOLTO: begin
        if (p) begin
          estado_d = CONFIRMA_APERTO;
          cnt_d    = '0;
        end
      end
      CONFIRMA_APERTO: begin
        if (!p) begin
          estado_d = SOLTO;
        end else if (cnt_q == CNT_MAX) begin
          estado_d   = APERTADO;
          confirma_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      APERTADO: begin
        if (!p) begin
          estado_d = CONFIRMA_SOLTURA;
          cnt_d    = '0;
        end
      end
      CONFIRMA_SOLTURA: begin
        // Bouncing back to pressed never re-issues a confirmation.
        if (p) begin
          estado_d = APERTADO;
        end else if (cnt_q == CNT_MAX) begin
          estado_d = SOLTO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: estado_d = SOLTO;
    endcase
  end

  assign estavel_o = (estado_q == APERTADO) || (estado_q == CONFIRMA_SOLTURA);

endmodule

// File: rtl/condicionador_botoes.sv
// Debounces N buttons, serialises confirmed presses into one-hot pulses
// (lowest index first) and counts issued pulses with saturation.
module condicionador_botoes
  import botoes_pkg::*;
#(
  parameter int N_BOTOES        = N_BOTOES_PADRAO,
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO,
  parameter int ATIVO_BAIXO     = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_BOTOES-1:0] botoes_brutos,
  input  logic                habilita,
  input  logic                limpa_jogadas,
  output logic [N_BOTOES-1:0] pulsos,
  output logic [N_BOTOES-1:0] estavel,
  output logic [7:0]          jogadas
);

  logic [N_BOTOES-1:0] confirma;
  logic [N_BOTOES-1:0] grant;
  logic [N_BOTOES-1:0] pend_q, pend_d;
  logic [N_BOTOES-1:0] pulsos_q, pulsos_d;
  logic [7:0]          jogadas_q, jogadas_d;

  for (genvar i = 0; i < N_BOTOES; i++) begin : g_botao
    debounce_botao #(
      .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
      .ATIVO_BAIXO     (ATIVO_BAIXO)
    ) u_debounce (
      .clk_i      (clk),
      .rst_i      (rst),
      .bruto_i    (botoes_brutos[i]),
      .estavel_o  (estavel[i]),
      .confirma_o (confirma[i])
    );
  end

  always_comb begin
    grant    = N_BOTOES'(menor_bit(32'(pend_q)));
    pulsos_d = grant;
    // Set is applied after the grant clear, so a same-cycle re-set keeps the bit pending.
    pend_d   = (pend_q & ~grant) | (confirma & {N_BOTOES{habilita}});
    jogadas_d = jogadas_q;
    if (limpa_jogadas) begin
      jogadas_d = '0;
    end else if ((|pulsos_q) && (jogadas_q != 8'hFF)) begin
      jogadas_d = jogadas_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      pulsos_q  <= '0;
      jogadas_q <= '0;
    end else begin
      pend_q    <= pend_d;
      pulsos_q  <= pulsos_d;
      jogadas_q <= jogadas_d;
    end
  end

  assign pulsos  = pulsos_q;
  assign jogadas = jogadas_q;

endmodule
